jtag_tap_ctrl: RTL and testbench
================================

Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller. It sequences the boundary-scan register (BSR) and internal-scan register (ISR) wrappers around the s9234 CUT.
- Decodes TMS/TDI on CK into the clockdr/updatedr/shiftdr/bs_en strobes (BSR) and clockdr_is/updatedr_is/shiftdr_is strobes (ISR).
- Holds the instruction register and 1-bit bypass register, and muxes the selected scan-out onto TDO.
- Single-clock: all strobes are CK-synchronous enables, not derived clocks.

Parameters:
- IR_W, 3, instruction register width.
- OP_EXTEST, 3'b000, select BSR, bs_en=1.
- OP_SAMPLE, 3'b001, select BSR, bs_en=0.
- OP_INTSCAN, 3'b010, select ISR, bs_en=1.
- OP_BYPASS, 3'b111, select bypass. All undefined opcodes also decode to bypass.

Ports:
- CK input 1 system/test clock; all state updates on rising edge.
- RST input 1 asynchronous, active-high reset.
- TMS input 1 test mode select, sampled on rising CK.
- TDI input 1 serial data in; also fans out to the BSR/ISR chains.
- TDO_BSR input 1 scan-out of boundary chain.
- TDO_ISR input 1 scan-out of internal chain.
- clockdr output 1 BSR capture/shift enable.
- updatedr output 1 BSR update strobe.
- shiftdr output 1 BSR shift select (1=shift, 0=capture).
- clockdr_is output 1 ISR capture/shift enable.
- updatedr_is output 1 ISR update strobe.
- shiftdr_is output 1 ISR shift select.
- bs_en output 1 boundary/test mode enable to the wrappers.
- TDO output 1 registered serial out.
- tdo_en output 1 high while TDO is valid (Shift-DR or Shift-IR).
- tap_state output 4 current TAP state, for debug and verification.

Behaviour:
- FSM has the 16 standard TAP states, with standard TMS transitions:
  - TLR -> RTI on TMS=0; stays on 1.
  - RTI -> SelDR on 1.
  - SelDR -> CapDR on 0, SelIR on 1.
  - SelIR -> CapIR on 0, TLR on 1.
  - Cap -> Shift on 0, Exit1 on 1.
  - Shift stays on 0, -> Exit1 on 1.
  - Exit1 -> Pause on 0, Update on 1.
  - Pause stays on 0, -> Exit2 on 1.
  - Exit2 -> Shift on 0, Update on 1.
  - Update -> RTI on 0, SelDR on 1.
- Five consecutive TMS=1 cycles reach TLR from any state.
- RST (async) forces:
  - state TLR, IR=OP_BYPASS, bypass=0, TDO=0.
  - all outputs 0, effective immediately.
  - Reset mid-shift discards partial IR/DR contents.
- In TLR the IR is synchronously reloaded with OP_BYPASS every cycle.
- Strobes are Moore-decoded from the state register, gated by the selected DR. Only the selected chain's strobes may assert; the others are held 0.
  - clockdr/clockdr_is = 1 in CapDR and ShiftDR.
  - shiftdr/shiftdr_is = 1 in ShiftDR only.
  - updatedr/updatedr_is = 1 for exactly one CK in UpdDR.
- bs_en:
  - Updated only in UpdIR, from the new IR value.
  - Holds through DR scans; cleared in TLR.
  - Never toggles during ShiftDR.
- IR path:
  - CapIR loads shift reg with {0..0,01}.
  - ShiftIR shifts right, TDI into the MSB, LSB out.
  - UpdIR copies the shift reg to IR. IR is unchanged by Pause/Exit.
- Bypass: CapDR loads 0; ShiftDR loads TDI.
- TDO:
  - Registered on rising CK: during ShiftIR it takes the IR shift LSB; during ShiftDR it takes the selected source (TDO_BSR, TDO_ISR or bypass).
  - Otherwise 0.
  - tdo_en mirrors the Shift states with the same one-cycle register delay.
- Latency: TDI bit in ShiftDR bypass appears on TDO 2 CK later (bypass reg + TDO reg).

Decomposition:
- Shared package jtag_pkg holds:
  - 4-bit tap_state_t enum with the 16 state encodings (TLR=4'hF per IEEE table).
  - Opcode constants and IR_W.
- One natural sub-module, jtag_tap_fsm: the pure 16-state TMS FSM with state output.
- The top adds the IR, bypass, decode and TDO mux.

Test Plan:
- RST pulse mid-ShiftDR -> tap_state=TLR and all strobes/TDO 0 immediately; after release, IR reads OP_BYPASS.
- From any state, TMS=1 x5 -> TLR. Then TMS=0 -> RTI; strobes stay 0.
- Load IR=000 via ShiftIR (TDI 0,0,0) -> TDO during shift returns 1,0,0. Exactly the UpdIR cycle sets bs_en=1.
- With EXTEST, enter CapDR then 4 ShiftDR cycles then UpdDR:
  - clockdr high 5 cycles; shiftdr high 4.
  - updatedr pulses 1 cycle.
  - ISR strobes stay 0; TDO follows TDO_BSR delayed 1.
- Load OP_INTSCAN -> only *_is strobes assert in DR scan, TDO follows TDO_ISR, bs_en=1.
- Opcode 3'b101 then ShiftDR of TDI=1,0,1,1 -> TDO = 0 (captured), 1, 0, 1, and no BSR/ISR strobes assert.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP controller definitions: state encodings, opcodes and decode helpers.
package jtag_pkg;

  localparam int IR_W = 3;

  localparam logic [IR_W-1:0] OP_EXTEST  = 3'b000;
  localparam logic [IR_W-1:0] OP_SAMPLE  = 3'b001;
  localparam logic [IR_W-1:0] OP_INTSCAN = 3'b010;
  localparam logic [IR_W-1:0] OP_BYPASS  = 3'b111;

  // Value loaded into the IR shift register in Capture-IR.
  localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b0}}, 2'b01};

  // IEEE 1149.1 state encodings.
  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0,
    EXIT1_DR = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8,
    EXIT1_IR = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  // Which data register an instruction connects between TDI and TDO.
  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_BSR    = 2'd1,
    DR_ISR    = 2'd2
  } dr_sel_t;

  // Data register selected by an opcode; anything undefined falls back to bypass.
  function automatic dr_sel_t op_dr_sel(input logic [IR_W-1:0] op);
    dr_sel_t sel;
    case (op)
      OP_EXTEST:  sel = DR_BSR;
      OP_SAMPLE:  sel = DR_BSR;
      OP_INTSCAN: sel = DR_ISR;
      default:    sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

  // Test-mode enable implied by an opcode.
  function automatic logic op_bs_en(input logic [IR_W-1:0] op);
    logic en;
    case (op)
      OP_EXTEST:  en = 1'b1;
      OP_INTSCAN: en = 1'b1;
      default:    en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine driven by TMS; exposes the registered state only.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       ck,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_nxt;

  // State register; reset parks the controller in Test-Logic-Reset.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= TLR;
    end else begin
      state <= state_nxt;
    end
  end

  // Standard TMS transition table.
  always_comb begin
    state_nxt = state;
    case (state)
      TLR:      state_nxt = tms ? TLR      : RTI;
      RTI:      state_nxt = tms ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_nxt = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_nxt = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_nxt = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_nxt = tms ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_nxt = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_nxt = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_nxt = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_nxt = tms ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction register, bypass register, BSR/ISR strobe
// decode and registered TDO mux around the TMS state machine.
module jtag_tap_ctrl
  import jtag_pkg::*;
(
  input  logic       CK,
  input  logic       RST,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       TDO_BSR,
  input  logic       TDO_ISR,
  output logic       clockdr,
  output logic       updatedr,
  output logic       shiftdr,
  output logic       clockdr_is,
  output logic       updatedr_is,
  output logic       shiftdr_is,
  output logic       bs_en,
  output logic       TDO,
  output logic       tdo_en,
  output logic [3:0] tap_state
);

  tap_state_t      state;
  logic [IR_W-1:0] ir;
  logic [IR_W-1:0] ir_sr;
  logic            byp;
  dr_sel_t         dr_sel;
  logic            dr_tdo;
  logic            in_cap_or_shift_dr;

  jtag_tap_fsm u_fsm (
    .ck    (CK),
    .rst   (RST),
    .tms   (TMS),
    .state (state)
  );

  assign tap_state = state;
  assign dr_sel    = op_dr_sel(ir);

  // IR shift register: capture the fixed pattern, then shift right with TDI into the MSB.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      ir_sr <= '0;
    end else if (state == CAP_IR) begin
      ir_sr <= IR_CAPTURE;
    end else if (state == SHIFT_IR) begin
      ir_sr <= {TDI, ir_sr[IR_W-1:1]};
    end
  end

  // Instruction register: forced to BYPASS in TLR, loaded only on Update-IR.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      ir <= OP_BYPASS;
    end else if (state == TLR) begin
      ir <= OP_BYPASS;
    end else if (state == UPD_IR) begin
      ir <= ir_sr;
    end
  end

  // Test-mode enable follows the newly loaded instruction, so it can never change mid DR scan.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      bs_en <= 1'b0;
    end else if (state == TLR) begin
      bs_en <= 1'b0;
    end else if (state == UPD_IR) begin
      bs_en <= op_bs_en(ir_sr);
    end
  end

  // One-bit bypass register: cleared on capture, samples TDI while shifting.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      byp <= 1'b0;
    end else if (state == CAP_DR) begin
      byp <= 1'b0;
    end else if (state == SHIFT_DR) begin
      byp <= TDI;
    end
  end

  // Serial-out source for the currently selected data register.
  always_comb begin
    dr_tdo = byp;
    case (dr_sel)
      DR_BSR:  dr_tdo = TDO_BSR;
      DR_ISR:  dr_tdo = TDO_ISR;
      default: dr_tdo = byp;
    endcase
  end

  // Registered TDO and its valid flag; both are zero outside the Shift states.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      TDO    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      TDO    <= 1'b0;
      tdo_en <= 1'b0;
      if (state == SHIFT_IR) begin
        TDO    <= ir_sr[0];
        tdo_en <= 1'b1;
      end else if (state == SHIFT_DR) begin
        TDO    <= dr_tdo;
        tdo_en <= 1'b1;
      end
    end
  end

  assign in_cap_or_shift_dr = (state == CAP_DR) || (state == SHIFT_DR);

  // Moore strobe decode; only the chain selected by the IR sees any activity.
  always_comb begin
    clockdr     = 1'b0;
    shiftdr     = 1'b0;
    updatedr    = 1'b0;
    clockdr_is  = 1'b0;
    shiftdr_is  = 1'b0;
    updatedr_is = 1'b0;
    case (dr_sel)
      DR_BSR: begin
        clockdr  = in_cap_or_shift_dr;
        shiftdr  = (state == SHIFT_DR);
        updatedr = (state == UPD_DR);
      end
      DR_ISR: begin
        clockdr_is  = in_cap_or_shift_dr;
        shiftdr_is  = (state == SHIFT_DR);
        updatedr_is = (state == UPD_DR);
      end
      default: begin
        clockdr = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed table-driven bench for jtag_tap_ctrl.
module tb_jtag_tap_ctrl;

  logic       CK = 1'b0;
  logic       RST;
  logic       TMS;
  logic       TDI;
  logic       TDO_BSR;
  logic       TDO_ISR;
  logic       clockdr;
  logic       updatedr;
  logic       shiftdr;
  logic       clockdr_is;
  logic       updatedr_is;
  logic       shiftdr_is;
  logic       bs_en;
  logic       TDO;
  logic       tdo_en;
  logic [3:0] tap_state;

  jtag_tap_ctrl dut (
    .CK          (CK),
    .RST         (RST),
    .TMS         (TMS),
    .TDI         (TDI),
    .TDO_BSR     (TDO_BSR),
    .TDO_ISR     (TDO_ISR),
    .clockdr     (clockdr),
    .updatedr    (updatedr),
    .shiftdr     (shiftdr),
    .clockdr_is  (clockdr_is),
    .updatedr_is (updatedr_is),
    .shiftdr_is  (shiftdr_is),
    .bs_en       (bs_en),
    .TDO         (TDO),
    .tdo_en      (tdo_en),
    .tap_state   (tap_state)
  );

  always #5 CK = ~CK;

  // Expected state codes (IEEE table).
  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDR = 4'h7, S_CDR = 4'h6;
  localparam logic [3:0] S_SHD = 4'h2, S_E1D = 4'h1, S_PSD = 4'h3, S_E2D = 4'h0;
  localparam logic [3:0] S_UDR = 4'h5, S_SIR = 4'h4, S_CIR = 4'hE, S_SHI = 4'hA;
  localparam logic [3:0] S_E1I = 4'h9, S_UIR = 4'hD;

  // Output bit masks: {clockdr, updatedr, shiftdr, clockdr_is, updatedr_is, shiftdr_is, bs_en, TDO, tdo_en}
  localparam logic [8:0] CD  = 9'b100000000;
  localparam logic [8:0] UD  = 9'b010000000;
  localparam logic [8:0] SD  = 9'b001000000;
  localparam logic [8:0] CDI = 9'b000100000;
  localparam logic [8:0] UDI = 9'b000010000;
  localparam logic [8:0] SDI = 9'b000001000;
  localparam logic [8:0] BS  = 9'b000000100;
  localparam logic [8:0] TD  = 9'b000000010;
  localparam logic [8:0] TE  = 9'b000000001;
  localparam logic [8:0] NO  = 9'b000000000;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic       bsr;
    logic       isr;
    logic [3:0] st;
    logic [8:0] out;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  logic       walk_bits [16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] walk_st   [16] = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5,
                                 4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

  function automatic logic [8:0] outs();
    return {clockdr, updatedr, shiftdr, clockdr_is, updatedr_is, shiftdr_is, bs_en, TDO, tdo_en};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic step(input logic tms, input logic tdi, input logic bsr, input logic isr);
    TMS = tms;
    TDI = tdi;
    TDO_BSR = bsr;
    TDO_ISR = isr;
    @(posedge CK);
    #1;
  endtask

  task automatic add(input logic tms, input logic tdi, input logic bsr, input logic isr,
                     input logic [3:0] st, input logic [8:0] out);
    vec_t v;
    v.tms = tms; v.tdi = tdi; v.bsr = bsr; v.isr = isr; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  // Load an opcode from RTI, LSB first, ending back in RTI.
  task automatic load_ir(input logic [2:0] op);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, op[0], 0, 0);
    step(0, op[1], 0, 0);
    step(1, op[2], 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    // Bypass-selected idle, then load EXTEST (000)
    add(1,0,0,0, S_TLR, NO);
    add(0,0,0,0, S_RTI, NO);
    add(0,0,0,0, S_RTI, NO);
    add(1,0,0,0, S_SDR, NO);
    add(1,0,0,0, S_SIR, NO);
    add(0,0,0,0, S_CIR, NO);
    add(0,0,0,0, S_SHI, NO);
    add(0,0,0,0, S_SHI, TD|TE);
    add(0,0,0,0, S_SHI, TE);
    add(1,0,0,0, S_E1I, TE);
    add(1,0,0,0, S_UIR, NO);
    add(0,0,0,0, S_RTI, BS);
    // EXTEST DR scan: capture + 4 shifts + update
    add(1,0,0,1, S_SDR, BS);
    add(0,0,0,1, S_CDR, CD|BS);
    add(0,0,1,0, S_SHD, CD|SD|BS);
    add(0,0,1,0, S_SHD, CD|SD|BS|TD|TE);
    add(0,0,0,1, S_SHD, CD|SD|BS|TE);
    add(0,0,1,0, S_SHD, CD|SD|BS|TD|TE);
    add(1,0,1,0, S_E1D, BS|TD|TE);
    add(1,0,0,1, S_UDR, UD|BS);
    add(0,0,0,0, S_RTI, BS);
    // Load INTSCAN (010)
    add(1,0,0,0, S_SDR, BS);
    add(1,0,0,0, S_SIR, BS);
    add(0,0,0,0, S_CIR, BS);
    add(0,0,0,0, S_SHI, BS);
    add(0,0,0,0, S_SHI, BS|TD|TE);
    add(0,1,0,0, S_SHI, BS|TE);
    add(1,0,0,0, S_E1I, BS|TE);
    add(1,0,0,0, S_UIR, BS);
    add(0,0,0,0, S_RTI, BS);
    // INTSCAN DR scan through Pause/Exit2
    add(1,0,1,0, S_SDR, BS);
    add(0,0,1,0, S_CDR, CDI|BS);
    add(0,0,1,0, S_SHD, CDI|SDI|BS);
    add(0,0,0,1, S_SHD, CDI|SDI|BS|TD|TE);
    add(1,0,1,0, S_E1D, BS|TE);
    add(0,0,0,0, S_PSD, BS);
    add(0,0,0,0, S_PSD, BS);
    add(1,0,0,0, S_E2D, BS);
    add(1,0,0,0, S_UDR, UDI|BS);
    add(0,0,0,0, S_RTI, BS);
    // Load undefined opcode 101
    add(1,0,0,0, S_SDR, BS);
    add(1,0,0,0, S_SIR, BS);
    add(0,0,0,0, S_CIR, BS);
    add(0,0,0,0, S_SHI, BS);
    add(0,1,0,0, S_SHI, BS|TD|TE);
    add(0,0,0,0, S_SHI, BS|TE);
    add(1,1,0,0, S_E1I, BS|TE);
    add(1,0,0,0, S_UIR, BS);
    add(0,0,0,0, S_RTI, NO);
    // Bypass DR scan, TDI 1,0,1,1
    add(1,0,1,1, S_SDR, NO);
    add(0,0,1,1, S_CDR, NO);
    add(0,0,1,1, S_SHD, NO);
    add(0,1,1,1, S_SHD, TE);
    add(0,0,1,1, S_SHD, TD|TE);
    add(0,1,1,1, S_SHD, TE);
    add(1,1,1,1, S_E1D, TD|TE);
    add(1,0,1,1, S_UDR, NO);
    add(0,0,1,1, S_RTI, NO);

    RST = 1'b1; TMS = 1'b1; TDI = 1'b0; TDO_BSR = 1'b0; TDO_ISR = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    check("reset state", 16'(tap_state), 16'(S_TLR));
    check("reset outputs", 16'(outs()), 16'(NO));
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].tms, vecs[i].tdi, vecs[i].bsr, vecs[i].isr);
      check($sformatf("vec%0d state", i), 16'(tap_state), 16'(vecs[i].st));
      check($sformatf("vec%0d outputs", i), 16'(outs()), 16'(vecs[i].out));
    end

    // Walk to every state, then five TMS=1 must land in TLR
    for (int k = 1; k <= 16; k++) begin
      repeat (5) step(1, 0, 0, 0);
      for (int j = 0; j < k; j++) step(walk_bits[j], 0, 0, 0);
      check($sformatf("walk%0d state", k), 16'(tap_state), 16'(walk_st[k-1]));
      repeat (5) step(1, 0, 0, 0);
      check($sformatf("walk%0d to tlr", k), 16'(tap_state), 16'(S_TLR));
    end
    step(0, 0, 0, 0);
    check("tlr to rti state", 16'(tap_state), 16'(S_RTI));
    check("rti outputs", 16'(outs()), 16'(NO));

    // Reset in the middle of an EXTEST shift
    load_ir(3'b000);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("pre-reset outputs", 16'(outs()), 16'(CD|SD|BS|TD|TE));
    RST = 1'b1;
    #1;
    check("async reset state", 16'(tap_state), 16'(S_TLR));
    check("async reset outputs", 16'(outs()), 16'(NO));
    @(posedge CK);
    #1;
    check("held reset state", 16'(tap_state), 16'(S_TLR));
    RST = 1'b0;
    step(0, 0, 1, 1);
    check("post-reset rti", 16'(outs()), 16'(NO));
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    check("post-reset capdr no strobes", 16'(outs()), 16'(NO));
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    check("post-reset bypass first", 16'(outs()), 16'(TE));
    step(1, 0, 1, 1);
    check("post-reset bypass tdi", 16'(outs()), 16'(TD|TE));
    check("post-reset exit1dr", 16'(tap_state), 16'(S_E1D));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
